shift_stage: RTL and testbench

Two-stage pipelined shift execution unit between instruction decode and register writeback. It accepts decoded shift operations under a valid/ready handshake and resolves the shift amount from an immediate or a register. It drives the combinational `barrel` shifter, then registers the 16-bit result together with N/Z/C flags for the writeback stage. Sustained throughput is one operation per cycle; latency is 2 cycles.

---
 rtl/shift_pkg.sv | 27 ++
 rtl/barrel.sv | 24 ++
 rtl/shift_stage.sv | 143 ++++++++++++++
 tb/tb_shift_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shift-type codes, widths and stage A operand bundle for shift_stage
package shift_pkg;

    localparam int SH_WIDTH = 16;
    localparam int SH_AMT_W = 4;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef struct packed {
        logic [1:0]          sh_type;
        logic [SH_AMT_W-1:0] amt;
        logic [SH_WIDTH-1:0] data;
    } stage_a_t;

    // Register-sourced amounts keep only the low bits, so shifts wrap modulo SH_WIDTH.
    function automatic logic [SH_AMT_W-1:0] sel_amt(
        input logic                src,
        input logic [SH_AMT_W-1:0] imm,
        input logic [SH_AMT_W-1:0] rs_lo
    );
        return src ? rs_lo : imm;
    endfunction

endpackage

// File: rtl/barrel.sv
// rtl/barrel.sv - combinational 16-bit barrel shifter: lsl, lsr, asr, ror
module barrel
    import shift_pkg::*;
(
    input  logic [SH_WIDTH-1:0] data_i,
    input  logic [SH_AMT_W-1:0] amt_i,
    input  logic [1:0]          type_i,
    output logic [SH_WIDTH-1:0] result_o
);

    logic [SH_AMT_W:0] rot_left;

    always_comb begin
        // For amt 0 the left term shifts by the full width and contributes nothing.
        rot_left = 5'(SH_WIDTH) - {1'b0, amt_i};
        case (type_i)
            SH_LSL:  result_o = data_i << amt_i;
            SH_LSR:  result_o = data_i >> amt_i;
            SH_ASR:  result_o = $signed(data_i) >>> amt_i;
            default: result_o = (data_i >> amt_i) | (data_i << rot_left);
        endcase
    end

endmodule

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - two-stage pipelined shift unit with N/Z flags; carry flag when SHIFT_STAGE_CARRY_EN is defined
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_type,
    input  logic             in_amt_src,
    input  logic [AMT_W-1:0] in_imm,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_n,
`ifdef SHIFT_STAGE_CARRY_EN
    output logic             out_c,
`endif
    output logic             out_z
);

    stage_a_t            a_q, a_d;
    logic                a_valid_q, a_valid_d;
    logic                b_valid_q, b_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic                out_n_q, out_n_d;
    logic                out_z_q, out_z_d;
    logic                b_adv;
    logic                accept;
    logic                load_b;
    logic [WIDTH-1:0]    sh_res;
    logic                unused_rs_hi;

    assign unused_rs_hi = ^in_rs[WIDTH-1:AMT_W];

    barrel u_barrel (
        .data_i   (a_q.data),
        .amt_i    (a_q.amt),
        .type_i   (a_q.sh_type),
        .result_o (sh_res)
    );

    always_comb begin
        b_adv    = a_valid_q & (~b_valid_q | out_ready);
        in_ready = ~flush & (~a_valid_q | b_adv);
        accept   = in_valid & in_ready;
        // Result registers hold still on a flush cycle; only the valids are killed.
        load_b   = b_adv & ~flush;

        a_d       = a_q;
        a_valid_d = a_valid_q;
        if (accept) begin
            a_valid_d  = 1'b1;
            a_d.sh_type = in_type;
            a_d.amt     = sel_amt(in_amt_src, in_imm, in_rs[AMT_W-1:0]);
            a_d.data    = in_data;
        end else if (b_adv) begin
            a_valid_d = 1'b0;
        end

        b_valid_d = b_valid_q;
        if (b_adv) begin
            b_valid_d = 1'b1;
        end else if (out_ready) begin
            b_valid_d = 1'b0;
        end

        if (flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end

        out_data_d = out_data_q;
        out_n_d    = out_n_q;
        out_z_d    = out_z_q;
        if (load_b) begin
            out_data_d = sh_res;
            out_n_d    = sh_res[WIDTH-1];
            out_z_d    = (sh_res == '0);
        end
    end

`ifdef SHIFT_STAGE_CARRY_EN
    logic             out_c_q, out_c_d;
    logic [AMT_W-1:0] lsl_idx;
    logic [AMT_W-1:0] lsr_idx;

    always_comb begin
        // 0 - n wraps to WIDTH - n, the last bit shifted out on a left shift.
        lsl_idx = '0 - a_q.amt;
        lsr_idx = a_q.amt - 1'b1;
        out_c_d = out_c_q;
        if (load_b && (a_q.amt != '0)) begin
            case (a_q.sh_type)
                SH_LSL:  out_c_d = a_q.data[lsl_idx];
                SH_LSR:  out_c_d = a_q.data[lsr_idx];
                SH_ASR:  out_c_d = a_q.data[lsr_idx];
                default: out_c_d = sh_res[WIDTH-1];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_c_q <= 1'b0;
        end else begin
            out_c_q <= out_c_d;
        end
    end

    assign out_c = out_c_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            out_data_q <= '0;
            out_n_q    <= 1'b0;
            out_z_q    <= 1'b1;
        end else begin
            a_q        <= a_d;
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            out_data_q <= out_data_d;
            out_n_q    <= out_n_d;
            out_z_q    <= out_z_d;
        end
    end

    assign out_valid = b_valid_q;
    assign out_data  = out_data_q;
    assign out_n     = out_n_q;
    assign out_z     = out_z_q;

endmodule

// File: tb/tb_shift_stage.sv
// tb/tb_shift_stage.sv - directed self-checking bench for shift_stage
module tb_shift_stage;

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;
    localparam logic [1:0] T_ROR = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_type = 2'b00;
    logic        in_amt_src = 1'b0;
    logic [3:0]  in_imm = 4'd0;
    logic [15:0] in_rs = 16'h0;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_n;
    logic        out_z;
`ifdef SHIFT_STAGE_CARRY_EN
    logic        out_c;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    shift_stage #(.WIDTH(16), .AMT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_amt_src (in_amt_src),
        .in_imm     (in_imm),
        .in_rs      (in_rs),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_n      (out_n),
`ifdef SHIFT_STAGE_CARRY_EN
        .out_c      (out_c),
`endif
        .out_z      (out_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] t, input logic src, input logic [3:0] imm,
                           input logic [15:0] rs, input logic [15:0] d);
        in_type    = t;
        in_amt_src = src;
        in_imm     = imm;
        in_rs      = rs;
        in_data    = d;
        in_valid   = 1'b1;
    endtask

    task automatic run_op(input logic [1:0] t, input logic src, input logic [3:0] imm,
                          input logic [15:0] rs, input logic [15:0] d);
        present(t, src, imm, rs, d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0000) $display("FAIL rst_out_data: got %h want 0000", out_data); else pass_cnt++;
        total_cnt++; if (out_n !== 1'b0) $display("FAIL rst_out_n: got %b want 0", out_n); else pass_cnt++;
        total_cnt++; if (out_z !== 1'b1) $display("FAIL rst_out_z: got %b want 1", out_z); else pass_cnt++;
`ifdef SHIFT_STAGE_CARRY_EN
        total_cnt++; if (out_c !== 1'b0) $display("FAIL rst_out_c: got %b want 0", out_c); else pass_cnt++;
`endif
    endtask

    task automatic test_lsl();
        run_op(T_LSL, 1'b0, 4'd4, 16'h0, 16'h0001);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL lsl_latency_early: got %b want 0", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL lsl_latency: got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0010) $display("FAIL lsl_data: got %h want 0010", out_data); else pass_cnt++;
        total_cnt++; if (out_n !== 1'b0 || out_z !== 1'b0) $display("FAIL lsl_nz: got n=%b z=%b want n=0 z=0", out_n, out_z); else pass_cnt++;
`ifdef SHIFT_STAGE_CARRY_EN
        total_cnt++; if (out_c !== 1'b0) $display("FAIL lsl_c: got %b want 0", out_c); else pass_cnt++;
`endif
    endtask

    task automatic test_ror_lsr();
        run_op(T_ROR, 1'b1, 4'd0, 16'h0011, 16'h8001);
        tick();
        total_cnt++; if (out_data !== 16'hC000) $display("FAIL ror_data: got %h want c000", out_data); else pass_cnt++;
        total_cnt++; if (out_n !== 1'b1) $display("FAIL ror_n: got %b want 1", out_n); else pass_cnt++;
`ifdef SHIFT_STAGE_CARRY_EN
        total_cnt++; if (out_c !== 1'b1) $display("FAIL ror_c: got %b want 1", out_c); else pass_cnt++;
`endif
        run_op(T_LSR, 1'b1, 4'd0, 16'h0011, 16'h8001);
        tick();
        total_cnt++; if (out_data !== 16'h4000) $display("FAIL lsr_data: got %h want 4000", out_data); else pass_cnt++;
        total_cnt++; if (out_n !== 1'b0) $display("FAIL lsr_n: got %b want 0", out_n); else pass_cnt++;
`ifdef SHIFT_STAGE_CARRY_EN
        total_cnt++; if (out_c !== 1'b1) $display("FAIL lsr_c: got %b want 1", out_c); else pass_cnt++;
`endif
    endtask

    task automatic test_asr();
        run_op(T_ASR, 1'b0, 4'd15, 16'h0, 16'h8000);
        tick();
        total_cnt++; if (out_data !== 16'hFFFF) $display("FAIL asr15_data: got %h want ffff", out_data); else pass_cnt++;
        total_cnt++; if (out_n !== 1'b1) $display("FAIL asr15_n: got %b want 1", out_n); else pass_cnt++;
`ifdef SHIFT_STAGE_CARRY_EN
        total_cnt++; if (out_c !== 1'b0) $display("FAIL asr15_c: got %b want 0", out_c); else pass_cnt++;
`endif
        run_op(T_LSR, 1'b0, 4'd1, 16'h0, 16'h0001);
        tick();
        total_cnt++; if (out_data !== 16'h0000 || out_z !== 1'b1) $display("FAIL lsr_to_zero: got %h z=%b want 0000 z=1", out_data, out_z); else pass_cnt++;
        run_op(T_ASR, 1'b0, 4'd0, 16'h0, 16'h8000);
        tick();
        total_cnt++; if (out_data !== 16'h8000) $display("FAIL asr0_data: got %h want 8000", out_data); else pass_cnt++;
`ifdef SHIFT_STAGE_CARRY_EN
        total_cnt++; if (out_c !== 1'b1) $display("FAIL asr0_c_kept: got %b want 1", out_c); else pass_cnt++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q [4];
        int nacc;
        int nout;
        logic acc;
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) exp_q[i] = 16'((i + 1) * 2);
        nacc = 0;
        nout = 0;
        present(T_LSL, 1'b0, 4'd1, 16'h0, 16'd1);
        for (int cyc = 0; cyc < 14; cyc++) begin
            out_ready = (cyc < 3) ? 1'b0 : 1'b1;
            #1;
            if (cyc == 2) begin
                total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready_full: got %b want 0", in_ready); else pass_cnt++;
                total_cnt++; if (out_valid !== 1'b1 || out_data !== 16'h0002) $display("FAIL b2b_held: got v=%b %h want v=1 0002", out_valid, out_data); else pass_cnt++;
            end
            acc = in_valid & in_ready;
            if (out_valid && out_ready) begin
                total_cnt++;
                if (nout >= 4) $display("FAIL b2b_extra_output: got %h want none", out_data);
                else if (out_data !== exp_q[nout]) $display("FAIL b2b_order[%0d]: got %h want %h", nout, out_data, exp_q[nout]);
                else pass_cnt++;
                nout++;
            end
            tick();
            if (acc) begin
                nacc++;
                if (nacc < 4) in_data = 16'(nacc + 1);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        total_cnt++; if (nout !== 4) $display("FAIL b2b_count: got %0d want 4", nout); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_op(T_LSL, 1'b0, 4'd1, 16'h0, 16'd5);
        run_op(T_LSL, 1'b0, 4'd1, 16'h0, 16'd6);
        present(T_LSL, 1'b0, 4'd1, 16'h0, 16'd7);
        flush = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else pass_cnt++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_not_accepted: got %b want 0", out_valid); else pass_cnt++;
        out_ready = 1'b1;
        run_op(T_LSL, 1'b0, 4'd2, 16'h0, 16'd3);
        tick();
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 16'h000C) $display("FAIL flush_next_op: got v=%b %h want v=1 000c", out_valid, out_data); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_op(T_LSL, 1'b0, 4'd1, 16'h0, 16'hC000);
        tick();
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 16'h8000) $display("FAIL rstmid_pre: got v=%b %h want v=1 8000", out_valid, out_data); else pass_cnt++;
`ifdef SHIFT_STAGE_CARRY_EN
        total_cnt++; if (out_c !== 1'b1) $display("FAIL rstmid_pre_c: got %b want 1", out_c); else pass_cnt++;
`endif
        run_op(T_LSL, 1'b0, 4'd1, 16'h0, 16'h0003);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 16'h0000 || out_n !== 1'b0 || out_z !== 1'b1) $display("FAIL rstmid_vals: got %h n=%b z=%b want 0000 n=0 z=1", out_data, out_n, out_z); else pass_cnt++;
`ifdef SHIFT_STAGE_CARRY_EN
        total_cnt++; if (out_c !== 1'b0) $display("FAIL rstmid_c: got %b want 0", out_c); else pass_cnt++;
`endif
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_no_pulse: got %b want 0", out_valid); else pass_cnt++;
        out_ready = 1'b1;
        run_op(T_LSL, 1'b0, 4'd3, 16'h0, 16'h0000);
        tick();
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_z !== 1'b1) $display("FAIL rstmid_zero_op: got v=%b %h z=%b want v=1 0000 z=1", out_valid, out_data, out_z); else pass_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lsl();
        test_ror_lsr();
        test_asr();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
